multicycle_datapath: RTL and testbench
======================================

Name: multicycle_datapath

Overview:
- Datapath slice directly downstream of the multicycle control FSM: consumes its control strobes, returns `op` and `zero`.
- Holds the architectural and intermediate registers PC, IR, MDR, A, B and ALUOut, plus the register file, ALU, ALU-control decode and operand muxes.
- Drives the address and write data for the unified instruction/data memory. Memory read data is combinational: valid in the same cycle as `adr`.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported, because the jump-target concatenation assumes it.
- REGBITS, 5, register-file index width (2**REGBITS registers).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- memdata  in  WIDTH  memory read data.
- irwrite  in  1  load IR from memdata.
- pcen  in  1  PC write enable; already combined by the FSM as pcwrite | (pcwritecond & zero).
- iord  in  1  address select: 0 = PC, 1 = ALUOut.
- alusrca  in  1  ALU A select: 0 = PC, 1 = A.
- alusrcb  in  2  ALU B select: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- aluop  in  2  00 = add, 01 = sub, 10 = decode funct, 11 = add.
- pcsource  in  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = ALU result.
- regwrite  in  1  register-file write enable.
- regdst  in  1  write index: 0 = IR[20:16], 1 = IR[15:11].
- memtoreg  in  1  write data: 0 = ALUOut, 1 = MDR.
- op  out  6  IR[31:26].
- zero  out  1  combinational; 1 when the current ALU result == 0.
- adr  out  WIDTH  memory address.
- writedata  out  WIDTH  memory write data (= B).

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - PC = RESET_PC; IR, MDR, A, B, ALUOut = 0.
  - Hence after reset: op = 0, adr = RESET_PC, writedata = 0.
  - Register-file contents are not reset.
  - Reset asserted mid-instruction aborts it: all listed registers are reinitialised at the next edge, and any regwrite in that cycle is suppressed.
- Per-edge register updates:
  - PC <= next-PC mux when pcen.
  - IR <= memdata when irwrite.
  - MDR <= memdata, A <= rd1, B <= rd2, ALUOut <= ALU result, every cycle unconditionally.
- Register file:
  - Two combinational read ports indexed by IR[25:21] and IR[20:16].
  - One synchronous write port, active on regwrite.
  - Register 0 always reads 0; writes to it are ignored.
  - Write and read of the same index in the same cycle: A/B capture the old value. No bypass.
- Immediates and jump target:
  - Sign-extend IR[15:0] to WIDTH; the shifted variant is that value << 2.
  - Jump target = {PC[31:28], IR[25:0], 2'b00}, using the current (already incremented) PC.
- ALU control, when aluop = 10, decoded from IR[5:0]:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed; result 1 or 0).
  - Any other funct: add.
- ALU arithmetic:
  - Arithmetic wraps modulo 2**WIDTH; no overflow flag or trap.
  - zero is derived from the live ALU result, not from ALUOut.
- adr = iord ? ALUOut : PC. No latency beyond the registers listed.
- Simultaneous irwrite and pcen (fetch): IR takes memdata at the old PC while PC takes PC+4, in the same edge.

Decomposition:
- Shared package holds:
  - opcode constants (LB, SB, RTYPE, BEQ, J);
  - funct constants;
  - aluop, alusrcb and pcsource encodings;
  - 3-bit ALU-control codes (ADD, SUB, AND, OR, SLT).
- The FSM imports the same package.
- One natural sub-module: `regfile` (2R1W, r0 hardwired zero).
- ALU, ALU decode and muxes stay inline.

Test Plan:
- Reset held 2 cycles with memdata = 0xFFFFFFFF, then released → adr = 0x0, op = 0, writedata = 0; with alusrca = 0, alusrcb = 00, aluop = 00, zero = 1.
- Fetch: memdata = 0x80A30004, irwrite = 1, pcen = 1, alusrcb = 01, pcsource = 00 → next cycle op = 0x20, PC = adr = 0x4, IR[15:0] = 0x0004.
- R-type: load r1 = 7 and r2 = 5 via the memtoreg path, then IR = 0x00221820 → execute (alusrca = 1, aluop = 10) gives ALUOut = 12; write (regdst = 1, regwrite = 1) gives r3 = 12. Repeat with funct 101010 and r1 = 0xFFFFFFFF, r2 = 1 → result 1.
- Branch: PC = 4, IR imm = 3 → decode (alusrcb = 11) gives ALUOut = 16. With A = B = 5 and aluop = 01, zero = 1; pcen = 1 with pcsource = 01 → PC = 16. With B = 6, zero = 0, pcen = 0 → PC stays 4.
- Jump: PC = 0x4, IR = 0x08000010, pcsource = 10, pcen = 1 → PC = 0x40.
- r0 and same-cycle write: regwrite to index 0 with ALUOut = 0xFFFF → reading r0 gives A = 0. Write r5 = 9 while IR[25:21] = 5 → A holds the old value that cycle and 9 the next.

Source files
------------

// File: rtl/multicycle_datapath_pkg.sv
// Shared encodings for the multicycle datapath and its control FSM.
package multicycle_datapath_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct field (IR[5:0])
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_ADD2  = 2'b11
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_B      = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10,
    PCSRC_ALU2   = 2'b11
  } pcsource_e;

  typedef enum logic [2:0] {
    ALUCTL_AND = 3'b000,
    ALUCTL_OR  = 3'b001,
    ALUCTL_ADD = 3'b010,
    ALUCTL_SUB = 3'b110,
    ALUCTL_SLT = 3'b111
  } aluctl_e;

endpackage

// File: rtl/multicycle_datapath_regfile.sv
// Two-read/one-write register file. Register 0 reads as zero and ignores writes.
// Contents are deliberately not reset.
module multicycle_datapath_regfile
  import multicycle_datapath_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [REGBITS-1:0] ra1_i,
  input  logic [REGBITS-1:0] ra2_i,
  input  logic [REGBITS-1:0] wa_i,
  input  logic [WIDTH-1:0]   wd_i,
  output logic [WIDTH-1:0]   rd1_o,
  output logic [WIDTH-1:0]   rd2_o
);

  logic [WIDTH-1:0] mem_q [2**REGBITS];

  // Synchronous write port; index 0 is never stored
  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != '0)) mem_q[wa_i] <= wd_i;
  end

  // Combinational reads, no write-to-read bypass
  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : mem_q[ra2_i];

endmodule

// File: rtl/multicycle_datapath.sv
// Multicycle CPU datapath: PC/IR/MDR/A/B/ALUOut registers, register file,
// ALU with funct decode, and the operand / next-PC / address muxes.
module multicycle_datapath
  import multicycle_datapath_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               REGBITS  = 5,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] memdata,
  input  logic             irwrite,
  input  logic             pcen,
  input  logic             iord,
  input  logic             alusrca,
  input  logic [1:0]       alusrcb,
  input  logic [1:0]       aluop,
  input  logic [1:0]       pcsource,
  input  logic             regwrite,
  input  logic             regdst,
  input  logic             memtoreg,
  output logic [5:0]       op,
  output logic             zero,
  output logic [WIDTH-1:0] adr,
  output logic [WIDTH-1:0] writedata
);

  logic [WIDTH-1:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, aluout_q, aluout_d;
  logic [WIDTH-1:0] rd1, rd2, rf_wd, sign_imm, jump_target;
  logic [WIDTH-1:0] srca, srcb, alu_result, pc_next;
  logic [REGBITS-1:0] rf_wa;
  aluctl_e          aluctl;

  // A write in a reset cycle belongs to an aborted instruction
  multicycle_datapath_regfile #(.WIDTH(WIDTH), .REGBITS(REGBITS)) u_regfile (
    .clk_i (clk),
    .we_i  (regwrite & ~reset),
    .ra1_i (ir_q[25:21]),
    .ra2_i (ir_q[20:16]),
    .wa_i  (rf_wa),
    .wd_i  (rf_wd),
    .rd1_o (rd1),
    .rd2_o (rd2)
  );

  assign rf_wa       = regdst ? ir_q[15:11] : ir_q[20:16];
  assign rf_wd       = memtoreg ? mdr_q : aluout_q;
  assign sign_imm    = {{(WIDTH-16){ir_q[15]}}, ir_q[15:0]};
  assign jump_target = {pc_q[WIDTH-1:WIDTH-4], ir_q[25:0], 2'b00};

  // ALU operand selection
  always_comb begin
    srca = alusrca ? a_q : pc_q;
    case (alusrcb)
      SRCB_B:    srcb = b_q;
      SRCB_FOUR: srcb = WIDTH'(4);
      SRCB_IMM:  srcb = sign_imm;
      default:   srcb = {sign_imm[WIDTH-3:0], 2'b00};
    endcase
  end

  // ALU control decode; unknown functs fall back to add
  always_comb begin
    aluctl = ALUCTL_ADD;
    case (aluop)
      ALUOP_SUB: aluctl = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        case (ir_q[5:0])
          FUNCT_SUB: aluctl = ALUCTL_SUB;
          FUNCT_AND: aluctl = ALUCTL_AND;
          FUNCT_OR:  aluctl = ALUCTL_OR;
          FUNCT_SLT: aluctl = ALUCTL_SLT;
          default:   aluctl = ALUCTL_ADD;
        endcase
      end
      default: aluctl = ALUCTL_ADD;
    endcase
  end

  // ALU datapath, wrapping arithmetic, signed set-less-than
  always_comb begin
    case (aluctl)
      ALUCTL_SUB: alu_result = srca - srcb;
      ALUCTL_AND: alu_result = srca & srcb;
      ALUCTL_OR:  alu_result = srca | srcb;
      ALUCTL_SLT: alu_result = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      default:    alu_result = srca + srcb;
    endcase
  end

  // Next-PC selection
  always_comb begin
    case (pcsource)
      PCSRC_ALUOUT: pc_next = aluout_q;
      PCSRC_JUMP:   pc_next = jump_target;
      default:      pc_next = alu_result;
    endcase
  end

  // Next-state for all datapath registers
  always_comb begin
    pc_d     = pcen ? pc_next : pc_q;
    ir_d     = irwrite ? memdata : ir_q;
    mdr_d    = memdata;
    a_d      = rd1;
    b_d      = rd2;
    aluout_d = alu_result;
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      mdr_q    <= mdr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      aluout_q <= aluout_d;
    end
  end

  assign op        = ir_q[31:26];
  assign zero      = (alu_result == '0);
  assign adr       = iord ? aluout_q : pc_q;
  assign writedata = b_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: drives control strobes step by step
// and checks op/zero/adr/writedata against hand-computed values.
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] memdata;
  logic        irwrite, pcen, iord, alusrca, regwrite, regdst, memtoreg;
  logic [1:0]  alusrcb, aluop, pcsource;
  logic [5:0]  op;
  logic        zero;
  logic [31:0] adr, writedata;

  int checks = 0;
  int failures = 0;

  multicycle_datapath dut (
    .clk(clk), .reset(reset), .memdata(memdata), .irwrite(irwrite), .pcen(pcen),
    .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
    .op(op), .zero(zero), .adr(adr), .writedata(writedata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Put val into register idx through MDR and the memtoreg path
  task automatic load_reg(input logic [4:0] idx, input logic [31:0] val);
    memdata = {11'b0, idx, 16'b0}; irwrite = 1'b1; tick();
    irwrite = 1'b0; memdata = val; tick();
    regwrite = 1'b1; memtoreg = 1'b1; regdst = 1'b0; tick();
    regwrite = 1'b0; memtoreg = 1'b0;
  endtask

  // Route register idx through A, ALU (+r0) and ALUOut onto adr
  task automatic read_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    memdata = {6'b0, idx, 21'b0}; irwrite = 1'b1; tick();
    irwrite = 1'b0; alusrca = 1'b1; alusrcb = 2'b00; aluop = 2'b00; tick();
    tick();
    iord = 1'b1; #1;
    chk(tag, adr, exp);
    iord = 1'b0;
  endtask

  logic [5:0]  funct_tab [6];
  logic [31:0] res_tab   [6];

  initial begin
    funct_tab[0] = 6'b100000; res_tab[0] = 32'd12;
    funct_tab[1] = 6'b100010; res_tab[1] = 32'd2;
    funct_tab[2] = 6'b100100; res_tab[2] = 32'd5;
    funct_tab[3] = 6'b100101; res_tab[3] = 32'd7;
    funct_tab[4] = 6'b101010; res_tab[4] = 32'd0;
    funct_tab[5] = 6'b000000; res_tab[5] = 32'd12;

    reset = 1'b1; memdata = 32'hFFFF_FFFF; irwrite = 0; pcen = 0; iord = 0;
    alusrca = 0; alusrcb = 2'b00; aluop = 2'b00; pcsource = 2'b00;
    regwrite = 0; regdst = 0; memtoreg = 0;
    tick(); tick();
    reset = 1'b0; #1;
    chk("reset_adr", adr, 32'h0);
    chk("reset_op", {26'b0, op}, 32'h0);
    chk("reset_wdata", writedata, 32'h0);
    chk("reset_zero", {31'b0, zero}, 32'h1);

    // Fetch: IR gets word at PC 0, PC becomes 4
    memdata = 32'h80A3_0004; irwrite = 1; pcen = 1; alusrcb = 2'b01; tick();
    irwrite = 0; pcen = 0; alusrcb = 2'b00;
    chk("fetch_op", {26'b0, op}, 32'h20);
    chk("fetch_pc", adr, 32'h4);

    // R-type funct decode with r1=7, r2=5
    load_reg(5'd1, 32'd7);
    load_reg(5'd2, 32'd5);
    memdata = 32'h0022_1820; irwrite = 1; tick();
    irwrite = 0; tick();
    chk("rtype_b", writedata, 32'd5);
    for (int i = 0; i < 6; i++) begin
      memdata = {16'h0022, 5'd3, 5'd0, funct_tab[i]}; irwrite = 1;
      alusrca = 1; alusrcb = 2'b00; aluop = 2'b10; tick();
      irwrite = 0; #1;
      chk($sformatf("funct%0d_zero", i), {31'b0, zero}, {31'b0, res_tab[i] == 32'd0});
      tick();
      iord = 1; #1;
      chk($sformatf("funct%0d_aluout", i), adr, res_tab[i]);
      iord = 0;
    end
    // Write back the add result to r3 (IR rd=3, funct unknown -> add)
    regdst = 1; memtoreg = 0; regwrite = 1; tick();
    regwrite = 0; regdst = 0;
    read_reg(5'd3, 32'd12, "rtype_r3");

    // Signed slt: -1 < 1
    load_reg(5'd1, 32'hFFFF_FFFF);
    load_reg(5'd2, 32'd1);
    memdata = 32'h0022_182A; irwrite = 1; tick();
    irwrite = 0; alusrca = 1; alusrcb = 2'b00; aluop = 2'b10; tick();
    tick();
    iord = 1; #1;
    chk("slt_signed", adr, 32'd1);
    iord = 0;

    // Branch not taken: A=5, B=6
    load_reg(5'd1, 32'd5);
    load_reg(5'd2, 32'd6);
    memdata = 32'h1022_0003; irwrite = 1; tick();
    irwrite = 0; alusrca = 0; alusrcb = 2'b11; aluop = 2'b00; tick();
    iord = 1; #1;
    chk("beq_nt_target", adr, 32'd16);
    iord = 0; alusrca = 1; alusrcb = 2'b00; aluop = 2'b01; #1;
    chk("beq_nt_zero", {31'b0, zero}, 32'h0);
    tick();
    chk("beq_nt_pc", adr, 32'h4);

    // Branch taken: A=B=5
    load_reg(5'd2, 32'd5);
    memdata = 32'h1022_0003; irwrite = 1; tick();
    irwrite = 0; alusrca = 0; alusrcb = 2'b11; aluop = 2'b00; tick();
    iord = 1; #1;
    chk("beq_t_target", adr, 32'd16);
    iord = 0; alusrca = 1; alusrcb = 2'b00; aluop = 2'b01; #1;
    chk("beq_t_zero", {31'b0, zero}, 32'h1);
    pcen = 1; pcsource = 2'b01; tick();
    pcen = 0; pcsource = 2'b00;
    chk("beq_t_pc", adr, 32'd16);

    // Reset mid-instruction suppresses a pending write to r2
    memdata = 32'h0000_DEAD; tick();
    reset = 1; regwrite = 1; memtoreg = 1; regdst = 0; tick();
    reset = 0; regwrite = 0; memtoreg = 0; alusrca = 0; aluop = 2'b00; #1;
    chk("abort_adr", adr, 32'h0);
    chk("abort_op", {26'b0, op}, 32'h0);
    chk("abort_wdata", writedata, 32'h0);

    // Jump: fetch at 0 then PC = {PC[31:28], IR[25:0], 00}
    memdata = 32'h0800_0010; irwrite = 1; pcen = 1; alusrcb = 2'b01; tick();
    irwrite = 0;
    chk("jump_op", {26'b0, op}, 32'h2);
    chk("jump_pc4", adr, 32'h4);
    pcsource = 2'b10; tick();
    pcen = 0; pcsource = 2'b00; alusrcb = 2'b00;
    chk("jump_pc", adr, 32'h40);
    read_reg(5'd2, 32'd5, "abort_r2_kept");

    // Write to r0 is ignored
    load_reg(5'd6, 32'h0000_FFFF);
    memdata = 32'h00C0_0020; irwrite = 1; tick();
    irwrite = 0; alusrca = 1; alusrcb = 2'b00; aluop = 2'b00; tick();
    tick();
    iord = 1; #1;
    chk("r0_src", adr, 32'h0000_FFFF);
    iord = 0; regwrite = 1; regdst = 1; memtoreg = 0; tick();
    regwrite = 0; regdst = 0;
    read_reg(5'd0, 32'h0, "r0_zero");

    // Same-cycle write/read of r5: old value captured, new one next cycle
    load_reg(5'd5, 32'd3);
    memdata = 32'h00A5_0000; irwrite = 1; tick();
    irwrite = 0; memdata = 32'd9; tick();
    regwrite = 1; memtoreg = 1; regdst = 0; alusrca = 1; alusrcb = 2'b01; aluop = 2'b00; tick();
    regwrite = 0; memtoreg = 0;
    chk("samecyc_old", writedata, 32'd3);
    tick();
    chk("samecyc_new", writedata, 32'd9);
    iord = 1; #1;
    chk("samecyc_a_old", adr, 32'd7);
    tick();
    chk("samecyc_a_new", adr, 32'd13);
    iord = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
